// File: rtl/klein_pkg.sv
// Shared types and constants for the KLEIN-64 mode controller and core.
package klein_pkg;

    typedef logic [63:0] block_t;

    localparam logic MODE_ECB = 1'b0;
    localparam logic MODE_CBC = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KINIT,
        ST_KWAIT,
        ST_ACCEPT,
        ST_NEXT,
        ST_RWAIT,
        ST_OUT
    } state_t;

    // KLEIN 4-bit S-box; it is an involution, so it also serves as its own inverse.
    function automatic logic [3:0] klein_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h7;
            4'h1: y = 4'h4;
            4'h2: y = 4'hA;
            4'h3: y = 4'h9;
            4'h4: y = 4'h1;
            4'h5: y = 4'hF;
            4'h6: y = 4'hB;
            4'h7: y = 4'h0;
            4'h8: y = 4'hC;
            4'h9: y = 4'h3;
            4'hA: y = 4'h2;
            4'hB: y = 4'h6;
            4'hC: y = 4'h8;
            4'hD: y = 4'hE;
            4'hE: y = 4'hD;
            default: y = 4'h5;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/klein_core.sv
// Iterative KLEIN-64 block cipher: 12-cycle key setup on iinit, 12-cycle block on inext.
module klein_core
    import klein_pkg::*;
(
    input  logic   iclk,
    input  logic   ireset,
    input  logic   iinit,
    input  logic   inext,
    input  logic   iencdec,
    input  block_t ikey,
    input  block_t iblock,
    output logic   oready,
    output block_t oresult,
    output logic   oresult_valid
);

    localparam logic [3:0] NR = 4'd12;

    block_t     state_r, key_r, sk1_r, sk13_r, result_r;
    logic [3:0] round_r;
    logic       kbusy_r, bbusy_r, enc_r, ready_r, valid_r;
    block_t     ks_out, iks_out, enc_out, dec_out;

    function automatic block_t sub_nib(input block_t x);
        block_t y;
        y = '0;
        for (int unsigned i = 0; i < 16; i++)
            y[4*i +: 4] = klein_sbox(x[4*i +: 4]);
        return y;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    function automatic block_t mix(input block_t x);
        return {mix_col(x[63:32]), mix_col(x[31:0])};
    endfunction

    // The AES column matrix has order 4, so three applications give its inverse.
    function automatic block_t inv_mix(input block_t x);
        return mix(mix(mix(x)));
    endfunction

    function automatic block_t key_sched(input block_t k, input logic [3:0] i);
        logic [31:0] ar, br, na, nb;
        ar = {k[55:32], k[63:56]};
        br = {k[23:0],  k[31:24]};
        na = br;
        nb = ar ^ br;
        na[15:8]  = na[15:8] ^ {4'h0, i};
        nb[23:8]  = sub_nib({48'h0, nb[23:8]})[15:0];
        return {na, nb};
    endfunction

    function automatic block_t inv_key_sched(input block_t k, input logic [3:0] i);
        logic [31:0] na, nb, ar, br;
        na = k[63:32];
        nb = k[31:0];
        nb[23:8] = sub_nib({48'h0, nb[23:8]})[15:0];
        na[15:8] = na[15:8] ^ {4'h0, i};
        br = na;
        ar = nb ^ br;
        return {ar[7:0], ar[31:8], br[7:0], br[31:8]};
    endfunction

    always_comb begin
        ks_out  = key_sched(key_r, round_r);
        iks_out = inv_key_sched(key_r, round_r);
        enc_out = mix({sub_nib(state_r ^ key_r)} << 16 | {sub_nib(state_r ^ key_r)} >> 48);
        dec_out = sub_nib({inv_mix(state_r)} >> 16 | {inv_mix(state_r)} << 48) ^ iks_out;
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            state_r  <= '0;
            key_r    <= '0;
            sk1_r    <= '0;
            sk13_r   <= '0;
            result_r <= '0;
            round_r  <= '0;
            kbusy_r  <= 1'b0;
            bbusy_r  <= 1'b0;
            enc_r    <= 1'b0;
            ready_r  <= 1'b0;
            valid_r  <= 1'b0;
        end else if (iinit) begin
            key_r   <= ikey;
            sk1_r   <= ikey;
            round_r <= 4'd1;
            kbusy_r <= 1'b1;
            bbusy_r <= 1'b0;
            ready_r <= 1'b0;
            valid_r <= 1'b0;
        end else if (inext && ready_r && !bbusy_r) begin
            enc_r   <= iencdec;
            bbusy_r <= 1'b1;
            valid_r <= 1'b0;
            if (iencdec) begin
                state_r <= iblock;
                key_r   <= sk1_r;
                round_r <= 4'd1;
            end else begin
                state_r <= iblock ^ sk13_r;
                key_r   <= sk13_r;
                round_r <= NR;
            end
        end else if (kbusy_r) begin
            key_r   <= ks_out;
            round_r <= round_r + 4'd1;
            if (round_r == NR) begin
                sk13_r  <= ks_out;
                kbusy_r <= 1'b0;
                ready_r <= 1'b1;
            end
        end else if (bbusy_r) begin
            if (enc_r) begin
                state_r <= enc_out;
                key_r   <= ks_out;
                round_r <= round_r + 4'd1;
                if (round_r == NR) begin
                    result_r <= enc_out ^ ks_out;
                    valid_r  <= 1'b1;
                    bbusy_r  <= 1'b0;
                end
            end else begin
                state_r <= dec_out;
                key_r   <= iks_out;
                round_r <= round_r - 4'd1;
                if (round_r == 4'd1) begin
                    result_r <= dec_out;
                    valid_r  <= 1'b1;
                    bbusy_r  <= 1'b0;
                end
            end
        end
    end

    assign oready        = ready_r;
    assign oresult       = result_r;
    assign oresult_valid = valid_r;

endmodule

// File: rtl/klein_mode_ctrl.sv
// ECB/CBC block-mode controller around klein_core; one block in flight.
// CBC chaining is built only when KLEIN_MODE_CBC_EN is defined.
module klein_mode_ctrl
    import klein_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic             iclk,
    input  logic             ireset,
    input  logic             istart,
    input  logic [63:0]      ikey,
    input  logic [63:0]      iiv,
    input  logic             imode,
    input  logic             iencdec,
    input  logic             in_valid,
    output logic             oin_ready,
    input  logic [63:0]      in_data,
    output logic             oout_valid,
    input  logic             iout_ready,
    output logic [63:0]      oout_data,
    output logic             obusy,
    output logic             oerror,
    output logic [CNT_W-1:0] ocount
);

    localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    state_t             state, state_nx;
    block_t             key_r, blk_r, out_r;
    logic               encdec_r, err_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WAIT_W-1:0]  wait_cnt;

    logic   core_init, core_next, core_ready, core_valid, timeout;
    block_t core_block, core_result, result_out;

    klein_core u_core (
        .iclk          (iclk),
        .ireset        (ireset),
        .iinit         (core_init),
        .inext         (core_next),
        .iencdec       (encdec_r),
        .ikey          (key_r),
        .iblock        (core_block),
        .oready        (core_ready),
        .oresult       (core_result),
        .oresult_valid (core_valid)
    );

`ifdef KLEIN_MODE_CBC_EN
    logic   mode_r;
    block_t chain_r;

    // Chain only advances when the output is consumed, so the core input stays stable.
    always_comb begin
        core_block = blk_r;
        result_out = core_result;
        if (mode_r == MODE_CBC && encdec_r)
            core_block = blk_r ^ chain_r;
        if (mode_r == MODE_CBC && !encdec_r)
            result_out = core_result ^ chain_r;
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            mode_r  <= MODE_ECB;
            chain_r <= '0;
        end else if (state == ST_IDLE && istart) begin
            mode_r  <= imode;
            chain_r <= iiv;
        end else if (state == ST_OUT && iout_ready) begin
            chain_r <= encdec_r ? out_r : blk_r;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{imode, iiv};
    assign core_block = blk_r;
    assign result_out = core_result;
`endif

    always_comb begin
        state_nx  = state;
        core_init = 1'b0;
        core_next = 1'b0;
        timeout   = 1'b0;
        case (state)
            ST_IDLE:   if (istart) state_nx = ST_KINIT;
            ST_KINIT: begin
                core_init = 1'b1;
                state_nx  = ST_KWAIT;
            end
            ST_KWAIT: begin
                if (core_ready && wait_cnt != '0) begin
                    state_nx = ST_ACCEPT;
                end else if (wait_cnt == WAIT_MAX) begin
                    timeout  = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            ST_ACCEPT: if (in_valid) state_nx = ST_NEXT;
            ST_NEXT: begin
                core_next = 1'b1;
                state_nx  = ST_RWAIT;
            end
            ST_RWAIT: begin
                if (core_valid) begin
                    state_nx = ST_OUT;
                end else if (wait_cnt == WAIT_MAX) begin
                    timeout  = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            ST_OUT:    if (iout_ready) state_nx = ST_ACCEPT;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            state    <= ST_IDLE;
            key_r    <= '0;
            encdec_r <= 1'b0;
            blk_r    <= '0;
            out_r    <= '0;
            err_r    <= 1'b0;
            cnt_r    <= '0;
            wait_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && istart) begin
                key_r    <= ikey;
                encdec_r <= iencdec;
                cnt_r    <= '0;
                err_r    <= 1'b0;
            end
            if (state == ST_KINIT || state == ST_NEXT)
                wait_cnt <= '0;
            else if (state == ST_KWAIT || state == ST_RWAIT)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            if (state == ST_ACCEPT && in_valid)
                blk_r <= in_data;
            if (state == ST_RWAIT && core_valid)
                out_r <= result_out;
            if (state == ST_OUT && iout_ready)
                cnt_r <= cnt_r + CNT_W'(1);
            if (timeout) begin
                err_r <= 1'b1;
                blk_r <= '0;
            end
        end
    end

    assign oin_ready  = (state == ST_ACCEPT);
    assign oout_valid = (state == ST_OUT);
    assign obusy      = (state != ST_IDLE);
    assign oout_data  = out_r;
    assign oerror     = err_r;
    assign ocount     = cnt_r;

endmodule
